// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Definitions shared by the UART transmitter and receiver on one serial link:
//   - uart_state_t : 2-bit frame state encoding (IDLE, START, DATA, STOP)
//   - DEFAULT_CLOCK_DIV : default clock cycles per bit (9600 bps at the nominal clock)
//   - half_div() : half-bit count used to find the middle of the start bit
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLOCK_DIV = 104;

  // Integer half of the bit period, truncated to the counter width.
  function automatic logic [15:0] half_div(input int div);
    half_div = 16'(div / 2);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input bit.
//   Parameters:
//     RST_VAL : value both flops take in reset (1 suits an idle-high serial line)
//   Ports:
//     clock : destination clock
//     reset : asynchronous, active-high reset
//     d     : asynchronous input
//     q     : synchronised output, two clock cycles behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; only q is safe to use in the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver. Synchronises rx, detects the start bit, samples each
//   data bit at mid-bit (LSB first) and checks the stop bit. A good byte is
//   held in data_out with a data_valid level until the consumer acknowledges.
//   Parameters:
//     CLOCK_DIV : clock cycles per bit, 4..65535, must match the transmitter
//   Ports:
//     clock      : system clock, rising edge
//     reset      : asynchronous, active-high reset
//     rx         : serial input, idle high, asynchronous to clock
//     read_ack   : one-cycle pulse, consumer has taken data_out
//     data_out   : last correctly framed byte, held until overwritten
//     data_valid : data_out holds an unread byte
//     frame_err  : one-cycle pulse when the stop bit is sampled low
//     overrun    : sticky, a byte completed while the previous one was unread
//     busy       : high while a frame is being received
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_DIV = DEFAULT_CLOCK_DIV
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       read_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Last count value of the half-bit start window and of a full bit period.
  localparam logic [15:0] HALF_LAST = half_div(CLOCK_DIV) - 16'd1;
  localparam logic [15:0] BIT_LAST  = 16'(CLOCK_DIV - 1);

  uart_state_t state;
  logic [15:0] clock_count;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        rx_s;
  logic        stop_sample;
  logic        byte_ok;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // The stop bit is sampled on the last count of STOP; a high level completes a byte.
  assign stop_sample = (state == STOP) && (clock_count == BIT_LAST);
  assign byte_ok     = stop_sample && rx_s;

  // Frame FSM together with the output holding register and handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clock_count <= 16'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // A completing byte takes priority over the ack: an ack in the same
      // cycle is consumed by the new byte, so data_valid stays set and overrun
      // is left alone. Without an ack an unread byte is overwritten.
      if (byte_ok) begin
        data_out   <= shift;
        data_valid <= 1'b1;
        if (data_valid && !read_ack) begin
          overrun <= 1'b1;
        end
      end else if (read_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state       <= START;
            clock_count <= 16'd0;
            busy        <= 1'b1;
          end
        end

        START: begin
          if (clock_count == HALF_LAST) begin
            clock_count <= 16'd0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went high again before mid start bit: treat as noise.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

        DATA: begin
          if (clock_count == BIT_LAST) begin
            shift[bit_idx] <= rx_s;
            clock_count    <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start bit be caught.
          if (clock_count == BIT_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            clock_count <= 16'd0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          clock_count <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed and randomised bench for uart_rx. Two receivers share one clock:
//   index 0 runs at CLOCK_DIV=8, index 1 at CLOCK_DIV=104. Serial frames are
//   generated bit by bit; expected outputs come from a byte-level model of the
//   valid/ack/overrun rules and from the arithmetic frame latency.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx[2];
  logic       read_ack[2];
  logic [7:0] data_out[2];
  logic       data_valid[2];
  logic       frame_err[2];
  logic       overrun[2];
  logic       busy[2];

  uart_rx #(.CLOCK_DIV(8)) dut8 (
    .clock(clock), .reset(reset), .rx(rx[0]), .read_ack(read_ack[0]),
    .data_out(data_out[0]), .data_valid(data_valid[0]), .frame_err(frame_err[0]),
    .overrun(overrun[0]), .busy(busy[0])
  );

  uart_rx #(.CLOCK_DIV(104)) dut104 (
    .clock(clock), .reset(reset), .rx(rx[1]), .read_ack(read_ack[1]),
    .data_out(data_out[1]), .data_valid(data_valid[1]), .frame_err(frame_err[1]),
    .overrun(overrun[1]), .busy(busy[1])
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observed event history, sampled on the falling edge.
  int   ferr_pulses[2] = '{0, 0};
  int   ferr_cycles[2] = '{0, 0};
  int   rise_cyc[2]    = '{0, 0};
  logic prev_ferr[2]   = '{1'b0, 1'b0};
  logic prev_dv[2]     = '{1'b0, 1'b0};

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (frame_err[i] === 1'b1) begin
        ferr_cycles[i]++;
        if (prev_ferr[i] !== 1'b1) ferr_pulses[i]++;
      end
      if (data_valid[i] === 1'b1 && prev_dv[i] !== 1'b1) rise_cyc[i] = cyc;
      prev_ferr[i] = frame_err[i];
      prev_dv[i]   = data_valid[i];
    end
  end

  // Byte-level reference model.
  logic [7:0] m_data[2];
  logic       m_valid[2];
  logic       m_ovr[2];
  int         m_ferr[2] = '{0, 0};

  int n_assert = 0;
  int n_fail   = 0;

  function automatic int cd_of(input int sel);
    return (sel != 0) ? 104 : 8;
  endfunction

  // Cycles from driving the start bit to seeing data_valid: two synchroniser
  // stages plus the sampling edge, half a bit, eight data bits and the stop bit.
  function automatic int latency_of(input int sel);
    return 3 + cd_of(sel) / 2 + 9 * cd_of(sel);
  endfunction

  task automatic chk(input string tag, input int sel, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (div %0d): observed %0h expected %0h", tag, cd_of(sel), obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int sel);
    chk({tag, ".data_out"},   sel, 32'(data_out[sel]),   32'(m_data[sel]));
    chk({tag, ".data_valid"}, sel, 32'(data_valid[sel]), 32'(m_valid[sel]));
    chk({tag, ".overrun"},    sel, 32'(overrun[sel]),    32'(m_ovr[sel]));
    chk({tag, ".ferr_pulses"}, sel, 32'(ferr_pulses[sel]), 32'(m_ferr[sel]));
    chk({tag, ".ferr_cycles"}, sel, 32'(ferr_cycles[sel]), 32'(m_ferr[sel]));
    chk({tag, ".busy"},       sel, 32'(busy[sel]),       32'd0);
  endtask

  task automatic model_frame(input int sel, input logic [7:0] b, input logic stop_bit, input logic ack_same);
    if (!stop_bit) begin
      m_ferr[sel]++;
    end else begin
      if (m_valid[sel] && !ack_same) m_ovr[sel] = 1'b1;
      m_data[sel]  = b;
      m_valid[sel] = 1'b1;
    end
  endtask

  task automatic model_ack(input int sel);
    if (m_valid[sel]) begin
      m_valid[sel] = 1'b0;
      m_ovr[sel]   = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
      m_ovr[i]   = 1'b0;
    end
  endtask

  // Called 1 time unit after a rising edge; drives start, 8 data bits LSB
  // first and the stop bit, then idles high for gap cycles.
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                            input int gap, output int c0);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    c0   = cyc;
    for (int i = 0; i < 10; i++) begin
      rx[sel] = bits[i];
      repeat (cd_of(sel)) @(posedge clock);
      #1;
    end
    rx[sel] = 1'b1;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic pulse_ack(input int sel);
    read_ack[sel] = 1'b1;
    @(posedge clock);
    #1;
    read_ack[sel] = 1'b0;
    model_ack(sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int c0;
    int c1;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx[i]       = 1'b1;
      read_ack[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_state("reset", 0);
    check_state("reset", 1);
    chk("reset.frame_err", 0, 32'(frame_err[0]), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Loopback-style traffic, fixed then random bytes, ack 5 cycles after valid.
    for (int k = 0; k < 8; k++) begin
      b = (k == 0) ? 8'hA5 : (k == 1) ? 8'h3C : 8'($urandom);
      send_frame(0, b, 1'b1, 16, c0);
      model_frame(0, b, 1'b1, 1'b0);
      chk("latency", 0, 32'(rise_cyc[0] - c0), 32'(latency_of(0)));
      check_state("loopback", 0);
      repeat (5) @(posedge clock);
      #1;
      pulse_ack(0);
      check_state("loopback_ack", 0);
    end

    // Glitch shorter than half a bit is rejected.
    c0 = cyc;
    rx[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("glitch.busy_seen", 0, 32'(busy[0]), 32'd1);
    rx[0] = 1'b1;
    repeat (16) @(posedge clock);
    #1;
    check_state("glitch", 0);

    // Framing error: stop bit low.
    send_frame(0, 8'h55, 1'b0, 16, c0);
    model_frame(0, 8'h55, 1'b0, 1'b0);
    check_state("framing", 0);

    // rx held low: one frame error, then an immediate restart.
    c0 = cyc;
    rx[0] = 1'b0;
    repeat (latency_of(0)) @(posedge clock);
    #1;
    chk("held_low.frame_err", 0, 32'(frame_err[0]), 32'd1);
    chk("held_low.busy_stop", 0, 32'(busy[0]), 32'd0);
    rx[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("held_low.restart", 0, 32'(busy[0]), 32'd1);
    chk("held_low.ferr_done", 0, 32'(frame_err[0]), 32'd0);
    repeat (16) @(posedge clock);
    #1;
    m_ferr[0]++;
    check_state("held_low", 0);

    // Overrun: two back-to-back bytes without ack.
    send_frame(0, 8'h11, 1'b1, 0, c0);
    model_frame(0, 8'h11, 1'b1, 1'b0);
    send_frame(0, 8'h22, 1'b1, 16, c0);
    model_frame(0, 8'h22, 1'b1, 1'b0);
    check_state("overrun", 0);
    pulse_ack(0);
    check_state("overrun_ack", 0);

    // Ack on the exact completion cycle of a second byte.
    b = 8'($urandom);
    send_frame(0, b, 1'b1, 0, c0);
    model_frame(0, b, 1'b1, 1'b0);
    fork
      send_frame(0, 8'h77, 1'b1, 16, c1);
      begin
        repeat (latency_of(0) - 1) @(posedge clock);
        #1;
        read_ack[0] = 1'b1;
        @(posedge clock);
        #1;
        read_ack[0] = 1'b0;
      end
    join
    model_frame(0, 8'h77, 1'b1, 1'b1);
    check_state("simultaneous", 0);

    // Reset while the receiver is in data bit 4; rx is high from bit 3 on.
    fork
      send_frame(0, 8'hF8, 1'b1, 16, c0);
      begin
        repeat (latency_of(0) - 5 * 8 + 2) @(posedge clock);
        #1;
        chk("mid_frame.busy", 0, 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          chk("in_reset.data_out",   i, 32'(data_out[i]),   32'd0);
          chk("in_reset.data_valid", i, 32'(data_valid[i]), 32'd0);
          chk("in_reset.frame_err",  i, 32'(frame_err[i]),  32'd0);
          chk("in_reset.overrun",    i, 32'(overrun[i]),    32'd0);
          chk("in_reset.busy",       i, 32'(busy[i]),       32'd0);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
      end
    join
    model_reset();
    check_state("after_reset", 0);
    send_frame(0, 8'hC3, 1'b1, 16, c0);
    model_frame(0, 8'hC3, 1'b1, 1'b0);
    chk("latency_c3", 0, 32'(rise_cyc[0] - c0), 32'(latency_of(0)));
    check_state("after_reset_c3", 0);
    pulse_ack(0);

    // Full-rate divider: fixed and random byte.
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      send_frame(1, b, 1'b1, 16, c0);
      model_frame(1, b, 1'b1, 1'b0);
      chk("latency104", 1, 32'(rise_cyc[1] - c0), 32'(latency_of(1)));
      check_state("div104", 1);
      repeat (5) @(posedge clock);
      #1;
      pulse_ack(1);
      check_state("div104_ack", 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
